mem_arbiter4: RTL and testbench
===============================

# mem_arbiter4

Round-robin arbiter that shares one memory port among four requesters (e.g. fetch, load/store, debug, DMA) in the rvsimple core. It drives the `sel` input of the four-way data/address multiplexer in front of the port, issues one-hot grants and completion pulses, and aborts transactions the memory never acknowledges. Decisions are registered, so the mux select is glitch-free and stable for the whole transaction.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum BUSY cycles without `mem_ready` before abort; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  input  1  rising-edge clock
- `reset_n`  input  1  asynchronous, active-low reset
- `req`  input  4  per-requester request level; bit i = requester i
- `mem_ready`  input  1  memory completes the current transaction this cycle
- `grant`  output  4  one-hot owner of the port; 0 when idle
- `sel`  output  2  index of the current or last owner; drives the 4-way mux select
- `mem_valid`  output  1  transaction in flight; equals |grant
- `done`  output  4  one-cycle pulse on bit i after requester i's transaction completes
- `timeout_err`  output  1  one-cycle pulse when a transaction is aborted
- `busy`  output  1  state == BUSY

## Operation
- Two states: IDLE and BUSY. Internal state: round-robin pointer `ptr[1:0]` and timeout counter `cnt` of width clog2(TIMEOUT+1).
- IDLE:
  - Form the effective request `eff = req & ~done`. A requester whose done pulse is high this cycle is masked for that cycle.
  - If `eff` is nonzero, choose the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the next edge: `sel` takes the chosen index, `grant` becomes one-hot at that index, `mem_valid` goes to 1, `cnt` goes to 0, and the state moves to BUSY.
  - If `eff` is zero, stay in IDLE; `sel` holds its last value.
- BUSY, at each edge:
  - If `mem_ready` is 1: set `done[sel]` for one cycle, clear `grant` and `mem_valid`, set `ptr` to sel+1 (mod 4), go to IDLE.
  - Else if TIMEOUT != 0 and `cnt` == TIMEOUT-1: set `timeout_err` for one cycle, clear `grant` and `mem_valid`, set `ptr` to sel+1, go to IDLE. No done pulse is issued.
  - Otherwise: increment `cnt`.
- `mem_ready` in the final timeout cycle takes priority: the result is normal completion, not timeout.
- `req` is ignored during BUSY. Deasserting req mid-transaction does not cancel the grant.
- `mem_ready` is ignored in IDLE.
- All outputs are registered except `busy` and `mem_valid`, which are direct state decodes.

## Timing
- Reset (asynchronous, immediate, including mid-BUSY):
  - state IDLE, `ptr` 0, `cnt` 0
  - `grant` 0000, `sel` 00, `mem_valid` 0, `done` 0000, `timeout_err` 0, `busy` 0
- Grant latency: req sampled high in IDLE at edge N gives grant and sel valid from N+1.
- Completion: `mem_ready` high in the BUSY cycle ending at edge M gives done pulse and idle during M..M+1.
- Minimum transaction period is 2 cycles (grant cycle + IDLE/done cycle). Continuous all-request load gives grant order 0,1,2,3,0,… with one grant every 2 cycles.
- Timeout: grant is held exactly TIMEOUT cycles; `timeout_err` is high in the following IDLE cycle.
- `sel` changes only on the edge entering BUSY.

## Test plan
- Reset: drive req=1111 and mem_ready=1, then pull reset_n low mid-BUSY. All outputs go 0 immediately, without waiting for a clock. After release, the first grant goes to requester 0.
- Single requester: req=0100 at cycle 0, mem_ready=1 at cycle 3.
  - Cycles 1-3: grant=0100, sel=2.
  - Cycle 4: done=0100, grant=0000.
- Round-robin fairness: req=1111 held, mem_ready=1 held. Grants 0,1,2,3,0 at cycles 1,3,5,7,9, and done pulses in the even cycles between. The requester holding req through its done cycle is not re-granted immediately.
- Pointer skip: first complete a grant to 1, then req=1001. Next grant is 3 (ptr=2 skips 2), then 0.
- Timeout with TIMEOUT=4 and mem_ready=0: grant=0010 in cycles 1-4, timeout_err=1 at cycle 5 with done=0000. Repeat with mem_ready=1 at cycle 4: done=0010 at cycle 5 and no timeout_err.
- Withdrawn request: req=0001 for one cycle only. Grant is still held until mem_ready, then done=0001 fires.

Source files
------------

// File: rtl/mem_arbiter4.sv
// Round-robin arbiter sharing one memory port among four requesters.
// Registered grant/sel keep the downstream mux select stable for a whole transaction.
module mem_arbiter4 #(
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       mem_ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       mem_valid,
    output logic [3:0] done,
    output logic       timeout_err,
    output logic       busy
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n, sel_n, pick;
    logic             found;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       eff, grant_n, done_n;
    logic             tmo_n;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // A requester that just got its done pulse is masked so it cannot be re-granted back to back.
    assign eff = req & ~done;

    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && eff[ptr + 2'(k)]) begin
                pick  = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        cnt_n   = cnt;
        grant_n = grant;
        done_n  = '0;
        tmo_n   = 1'b0;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (found) begin
                    state_n = BUSY;
                    sel_n   = pick;
                    grant_n = onehot(pick);
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mem_ready) begin
                    state_n = IDLE;
                    done_n  = onehot(sel);
                    grant_n = '0;
                    ptr_n   = sel + 2'd1;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    state_n = IDLE;
                    tmo_n   = 1'b1;
                    grant_n = '0;
                    ptr_n   = sel + 2'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            sel         <= '0;
            grant       <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            sel         <= sel_n;
            grant       <= grant_n;
            done        <= done_n;
            timeout_err <= tmo_n;
        end
    end

    assign busy      = (state == BUSY);
    assign mem_valid = (state == BUSY);

endmodule

// File: tb/tb_mem_arbiter4.sv
// Scoreboard bench for mem_arbiter4: stimulus queues expected grant/end events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_arbiter4;

    logic       clock;
    logic       reset_n;
    logic [3:0] req;
    logic       mem_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       mem_valid;
    logic [3:0] done;
    logic       timeout_err;
    logic       busy;

    mem_arbiter4 #(.TIMEOUT(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .mem_ready   (mem_ready),
        .grant       (grant),
        .sel         (sel),
        .mem_valid   (mem_valid),
        .done        (done),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    typedef struct {
        bit         is_end;
        int         idx;
        logic [3:0] dn;
        bit         tmo;
        int         cyc;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    bit  prev_mv = 1'b0;
    int  c0;
    int  c1;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_grant(input int idx, input int c);
        ev_t x;
        x.is_end = 1'b0; x.idx = idx; x.dn = 4'b0000; x.tmo = 1'b0; x.cyc = c;
        q.push_back(x);
    endtask

    task automatic exp_end(input int idx, input logic [3:0] dn, input bit tmo, input int c);
        ev_t x;
        x.is_end = 1'b1; x.idx = idx; x.dn = dn; x.tmo = tmo; x.cyc = c;
        q.push_back(x);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("events_pending", q.size(), 0);
        q.delete();
        repeat (2) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_sel"}, int'(sel), 0);
        chk({tag, "_mem_valid"}, int'(mem_valid), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_timeout_err"}, int'(timeout_err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Monitor: a grant event is the rise of mem_valid; an end event is any done/timeout pulse.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_mv = 1'b0;
        end else begin
            if (mem_valid && !prev_mv) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", int'(grant), 0);
                end else begin
                    e = q.pop_front();
                    chk("grant_kind", 0, int'(e.is_end));
                    chk("grant_cycle", cyc, e.cyc);
                    chk("grant_onehot", int'(grant), int'(4'b0001 << e.idx));
                    chk("grant_sel", int'(sel), e.idx);
                    chk("grant_busy", int'(busy), 1);
                end
            end
            if (done != 4'b0000 || timeout_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_end", int'({timeout_err, done}), 0);
                end else begin
                    e = q.pop_front();
                    chk("end_kind", 1, int'(e.is_end));
                    chk("end_cycle", cyc, e.cyc);
                    chk("end_done", int'(done), int'(e.dn));
                    chk("end_timeout_err", int'(timeout_err), int'(e.tmo));
                    chk("end_sel_held", int'(sel), e.idx);
                    chk("end_grant", int'(grant), 0);
                    chk("end_mem_valid", int'(mem_valid), 0);
                end
            end
            prev_mv = mem_valid;
        end
    end

    initial begin
        reset_n   = 1'b1;
        req       = 4'b0000;
        mem_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Round-robin under full load: 0,1,2,3,0 every two cycles.
        c0 = cyc;
        req = 4'b1111;
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_grant(k % 4, c0 + 1 + 2 * k);
            exp_end(k % 4, 4'b0001 << (k % 4), 1'b0, c0 + 2 + 2 * k);
        end
        repeat (9) tick();
        req = 4'b0000;
        drain(20);

        // Single requester 2, completion on cycle 3 (ptr is 1 here).
        mem_ready = 1'b0;
        c0 = cyc;
        req = 4'b0100;
        exp_grant(2, c0 + 1);
        exp_end(2, 4'b0100, 1'b0, c0 + 4);
        repeat (2) tick();
        chk("single_hold_grant", int'(grant), 4);
        chk("single_hold_sel", int'(sel), 2);
        tick();
        req = 4'b0000;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        drain(20);

        // Pointer skip: grant 1 first, then req=1001 goes to 3 then 0.
        c0 = cyc;
        req = 4'b0010;
        mem_ready = 1'b1;
        exp_grant(1, c0 + 1);
        exp_end(1, 4'b0010, 1'b0, c0 + 2);
        exp_grant(3, c0 + 3);
        exp_end(3, 4'b1000, 1'b0, c0 + 4);
        exp_grant(0, c0 + 5);
        exp_end(0, 4'b0001, 1'b0, c0 + 6);
        tick();
        req = 4'b1001;
        repeat (4) tick();
        req = 4'b0000;
        drain(20);

        // Timeout: TIMEOUT=4, no mem_ready; grant held cycles 1-4.
        mem_ready = 1'b0;
        c0 = cyc;
        req = 4'b0010;
        exp_grant(1, c0 + 1);
        exp_end(1, 4'b0000, 1'b1, c0 + 5);
        tick();
        req = 4'b0000;
        drain(20);

        // mem_ready in the final timeout cycle completes normally.
        c0 = cyc;
        req = 4'b0010;
        exp_grant(1, c0 + 1);
        exp_end(1, 4'b0010, 1'b0, c0 + 5);
        tick();
        req = 4'b0000;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        drain(20);

        // Withdrawn request: one-cycle req still completes (ptr is 2 here).
        c0 = cyc;
        req = 4'b0001;
        exp_grant(0, c0 + 1);
        exp_end(0, 4'b0001, 1'b0, c0 + 3);
        tick();
        req = 4'b0000;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        drain(20);

        // Asynchronous reset mid-BUSY while owner is 1; next grant after release goes to 0.
        c0 = cyc;
        req = 4'b1111;
        mem_ready = 1'b1;
        exp_grant(1, c0 + 1);
        tick();
        #6 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        chk("reset_events_pending", q.size(), 0);
        tick();
        reset_n = 1'b1;
        c1 = cyc;
        exp_grant(0, c1 + 1);
        exp_end(0, 4'b0001, 1'b0, c1 + 2);
        tick();
        req = 4'b0000;
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
